// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave that maps NREGS DLEN-bit registers onto the bus, with byte strobes and SLVERR decode.
// The write (AW/W/B) and read (AR/R) paths run independently. Register contents are exported flat on o_reg_q.
module axi_lite_regfile #(
    parameter int              ALEN      = 32,
    parameter int              DLEN      = 32,
    parameter int              SLEN      = DLEN / 8,
    parameter int              NREGS     = 16,
    parameter logic [DLEN-1:0] RESET_VAL = '0
) (
    input  logic                   i_aclk,
    input  logic                   i_aresetn,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [ALEN-1:0]        i_awaddr,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    input  logic [DLEN-1:0]        i_wdata,
    input  logic [SLEN-1:0]        i_wstrb,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    output logic [1:0]             o_bresp,
    input  logic                   i_arvalid,
    output logic                   o_arready,
    input  logic [ALEN-1:0]        i_araddr,
    output logic                   o_rvalid,
    input  logic                   i_rready,
    output logic [DLEN-1:0]        o_rdata,
    output logic [1:0]             o_rresp,
    output logic [NREGS*DLEN-1:0]  o_reg_q
);
    localparam int AB = $clog2(SLEN);
    localparam int IW = ALEN - AB;
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DLEN-1:0] r_regs [NREGS];
    logic            r_awHeld;
    logic [IW-1:0]   r_awIdx;
    logic            r_wHeld;
    logic [DLEN-1:0] r_wData;
    logic [SLEN-1:0] r_wStrb;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic            r_rvalid;
    logic [DLEN-1:0] r_rdata;
    logic [1:0]      r_rresp;

    logic [IW-1:0]   w_awIdx;
    logic [IW-1:0]   w_arIdx;
    logic            w_awHs;
    logic            w_wHs;
    logic            w_arHs;
    logic            w_commit;
    logic            w_wrOk;
    logic            w_arOk;
    logic [RW-1:0]   w_wrSel;
    logic [RW-1:0]   w_rdSel;

    // The byte-offset bits below the word index play no part in decode.
    assign w_awIdx  = i_awaddr[ALEN-1:AB];
    assign w_arIdx  = i_araddr[ALEN-1:AB];
    assign w_wrOk   = (r_awIdx < IW'(NREGS));
    assign w_arOk   = (w_arIdx < IW'(NREGS));
    assign w_wrSel  = r_awIdx[RW-1:0];
    assign w_rdSel  = w_arIdx[RW-1:0];

    assign o_awready = i_aresetn && !r_awHeld && !r_bvalid;
    assign o_wready  = i_aresetn && !r_wHeld && !r_bvalid;
    assign o_arready = i_aresetn && !r_rvalid;
    assign w_awHs    = i_awvalid && o_awready;
    assign w_wHs     = i_wvalid && o_wready;
    assign w_arHs    = i_arvalid && o_arready;
    assign w_commit  = r_awHeld && r_wHeld;

    // AW and W are captured independently. The write commits once both halves are held.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_awHeld <= 1'b0;
            r_awIdx  <= '0;
            r_wHeld  <= 1'b0;
            r_wData  <= '0;
            r_wStrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (w_awHs) begin
                r_awHeld <= 1'b1;
                r_awIdx  <= w_awIdx;
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= i_wdata;
                r_wStrb <= i_wstrb;
            end
            if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_commit && w_wrOk) begin
            for (int b = 0; b < SLEN; b++) begin
                if (r_wStrb[b]) begin
                    r_regs[w_wrSel][8*b +: 8] <= r_wData[8*b +: 8];
                end
            end
        end
    end

    // A read on the commit edge samples the register before the write lands.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_arHs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_arOk ? r_regs[w_rdSel] : '0;
            r_rresp  <= w_arOk ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign o_reg_q[g*DLEN +: DLEN] = r_regs[g];
    end

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus random traffic.
// Expected values come from a word-array model of the register file.
module tb_axi_lite_regfile;
    localparam int NREGS = 16;

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [31:0]           awaddr, araddr, wdata, rdata;
    logic [3:0]            wstrb;
    logic [1:0]            bresp, rresp;
    logic [NREGS*32-1:0]   regQ;

    int nCompared = 0;
    int nMismatched = 0;
    logic [31:0] model [NREGS];

    axi_lite_regfile #(.ALEN(32), .DLEN(32), .NREGS(NREGS), .RESET_VAL(32'h0)) dut (
        .i_aclk(clk), .i_aresetn(aresetn),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
        .o_reg_q(regQ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] regOf(input int i);
        return regQ[i*32 +: 32];
    endfunction

    function automatic logic [NREGS*32-1:0] modelFlat();
        logic [NREGS*32-1:0] f;
        for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // The model works on word indices. A write with an out-of-range index leaves the model untouched.
    function automatic logic [1:0] modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr / 4);
        if (idx >= NREGS) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx] = (model[idx] & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
        return 2'b00;
    endfunction

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bit awDone, wDone;
        awDone = 0; wDone = 0; n = 0;
        awvalid = 1; awaddr = addr; wvalid = 1; wdata = data; wstrb = strb; bready = 1;
        while (!(awDone && wDone) && n < 20) begin
            if (awvalid && awready) awDone = 1;
            if (wvalid && wready) wDone = 1;
            tick(); n++;
            if (awDone) awvalid = 0;
            if (wDone) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        resp = bresp;
        if (!bvalid) begin nCompared++; nMismatched++; $display("[TB] FAIL write_timeout addr=%h: got bvalid=%b, expected 1", addr, bvalid); end
        tick();
        bready = 0;
    endtask

    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        arvalid = 1; araddr = addr; rready = 1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        data = rdata; resp = rresp;
        if (!rvalid) begin nCompared++; nMismatched++; $display("[TB] FAIL read_timeout addr=%h: got rvalid=%b, expected 1", addr, rvalid); end
        tick();
        rready = 0;
    endtask

    task automatic test_reset();
        aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        tick(); tick();
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        nCompared++; if ({awready, wready, arready} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_readies: got %b, expected 000", {awready, wready, arready}); end
        nCompared++; if ({bvalid, rvalid} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_valids: got %b, expected 00", {bvalid, rvalid}); end
        nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdata); end
        nCompared++; if (regQ !== modelFlat()) begin nMismatched++; $display("[TB] FAIL reset_regq: got %h, expected %h", regQ, modelFlat()); end
        aresetn = 1;
        #1;
        nCompared++; if ({awready, wready, arready} !== 3'b111) begin nMismatched++; $display("[TB] FAIL post_reset_readies: got %b, expected 111", {awready, wready, arready}); end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [1:0] r;
        awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 0;
        nCompared++; if ({awready, wready} !== 2'b11) begin nMismatched++; $display("[TB] FAIL t1_ready: got %b, expected 11", {awready, wready}); end
        tick();
        awvalid = 0; wvalid = 0;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_b_early: got %b, expected 0", bvalid); end
        tick();
        void'(modelWrite(32'h08, 32'hDEADBEEF, 4'hF));
        nCompared++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin nMismatched++; $display("[TB] FAIL t1_bresp: got v=%b r=%b, expected v=1 r=00", bvalid, bresp); end
        nCompared++; if (regOf(2) !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL t1_regq2: got %h, expected deadbeef", regOf(2)); end
        bready = 1; tick(); bready = 0;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_b_drop: got %b, expected 0", bvalid); end
        doRead(32'h08, d, r);
        nCompared++; if (d !== model[2] || r !== 2'b00) begin nMismatched++; $display("[TB] FAIL t1_read: got %h/%b, expected %h/00", d, r, model[2]); end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] r;
        doWrite(32'h08, 32'h0000AB00, 4'h2, r);
        void'(modelWrite(32'h08, 32'h0000AB00, 4'h2));
        nCompared++; if (regOf(2) !== 32'hDEADABEF || r !== 2'b00) begin nMismatched++; $display("[TB] FAIL t2_strb2: got %h/%b, expected deadabef/00", regOf(2), r); end
        doWrite(32'h08, 32'hFFFFFFFF, 4'h0, r);
        nCompared++; if (regOf(2) !== model[2] || r !== 2'b00) begin nMismatched++; $display("[TB] FAIL t2_strb0: got %h/%b, expected %h/00", regOf(2), r, model[2]); end
    endtask

    task automatic test_w_before_aw();
        int extraB;
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; bready = 0;
        tick();
        wvalid = 0;
        nCompared++; if (wready !== 1'b0) begin nMismatched++; $display("[TB] FAIL t3_wready: got %b, expected 0", wready); end
        tick(); tick();
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL t3_b_before_aw: got %b, expected 0", bvalid); end
        awvalid = 1; awaddr = 32'h04;
        tick();
        awvalid = 0;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL t3_b_early: got %b, expected 0", bvalid); end
        tick();
        void'(modelWrite(32'h04, 32'h12345678, 4'hF));
        nCompared++; if (bvalid !== 1'b1 || regOf(1) !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL t3_commit: got v=%b reg1=%h, expected v=1 reg1=12345678", bvalid, regOf(1)); end
        bready = 1; tick(); bready = 0;
        extraB = 0;
        repeat (4) begin if (bvalid) extraB++; tick(); end
        nCompared++; if (extraB !== 0) begin nMismatched++; $display("[TB] FAIL t3_single_b: got %0d extra cycles, expected 0", extraB); end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0] r;
        doWrite(32'h40, 32'hFFFFFFFF, 4'hF, r);
        nCompared++; if (r !== modelWrite(32'h40, 32'hFFFFFFFF, 4'hF)) begin nMismatched++; $display("[TB] FAIL t4_bresp: got %b, expected 10", r); end
        nCompared++; if (regQ !== modelFlat()) begin nMismatched++; $display("[TB] FAIL t4_unchanged: got %h, expected %h", regQ, modelFlat()); end
        doRead(32'h40, d, r);
        nCompared++; if (d !== 32'h0 || r !== 2'b10) begin nMismatched++; $display("[TB] FAIL t4_read: got %h/%b, expected 0/10", d, r); end
        doWrite(32'h3C, 32'hCAFEF00D, 4'hF, r);
        nCompared++; if (r !== modelWrite(32'h3C, 32'hCAFEF00D, 4'hF)) begin nMismatched++; $display("[TB] FAIL t4_last_bresp: got %b, expected 00", r); end
        doRead(32'h3F, d, r);
        nCompared++; if (d !== 32'hCAFEF00D || r !== 2'b00) begin nMismatched++; $display("[TB] FAIL t4_last_read: got %h/%b, expected cafef00d/00", d, r); end
    endtask

    task automatic test_backpressure();
        bit stable;
        logic [1:0] r;
        logic [31:0] oldVal;
        awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'h0BADCAFE; wstrb = 4'hF; bready = 0;
        tick(); awvalid = 0; wvalid = 0; tick();
        void'(modelWrite(32'h0C, 32'h0BADCAFE, 4'hF));
        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'h99999999;
        stable = 1;
        repeat (5) begin
            if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) stable = 0;
            tick();
        end
        nCompared++; if (stable !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_b_stall: got stable=%b, expected 1", stable); end
        awvalid = 0; wvalid = 0; bready = 1; tick(); bready = 0; tick(); tick();
        nCompared++; if (bvalid !== 1'b0 || regOf(4) !== model[4]) begin nMismatched++; $display("[TB] FAIL t5_no_intrude: got v=%b reg4=%h, expected v=0 reg4=%h", bvalid, regOf(4), model[4]); end
        arvalid = 1; araddr = 32'h0C; rready = 0;
        tick();
        araddr = 32'h00;
        stable = 1;
        repeat (5) begin
            if (!(rvalid === 1'b1 && rdata === model[3] && rresp === 2'b00 && arready === 1'b0)) stable = 0;
            tick();
        end
        nCompared++; if (stable !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_r_stall: got stable=%b rdata=%h, expected 1 rdata=%h", stable, rdata, model[3]); end
        arvalid = 0; rready = 1; tick(); rready = 0;
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL t5_r_drop: got %b, expected 0", rvalid); end
        doWrite(32'h14, 32'h11112222, 4'hF, r);
        void'(modelWrite(32'h14, 32'h11112222, 4'hF));
        oldVal = model[5];
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF; bready = 0;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h14; rready = 0;
        tick();
        arvalid = 0;
        void'(modelWrite(32'h14, 32'h55AA55AA, 4'hF));
        nCompared++; if (rvalid !== 1'b1 || rdata !== oldVal) begin nMismatched++; $display("[TB] FAIL t5_same_edge: got v=%b rdata=%h, expected v=1 rdata=%h", rvalid, rdata, oldVal); end
        nCompared++; if (bvalid !== 1'b1 || regOf(5) !== model[5]) begin nMismatched++; $display("[TB] FAIL t5_same_edge_wr: got v=%b reg5=%h, expected v=1 reg5=%h", bvalid, regOf(5), model[5]); end
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    endtask

    task automatic test_reset_midflight();
        int nB;
        awvalid = 1; awaddr = 32'h18; arvalid = 1; araddr = 32'h08; rready = 0; bready = 0;
        tick();
        awvalid = 0; arvalid = 0;
        nCompared++; if (rvalid !== 1'b1 || awready !== 1'b0) begin nMismatched++; $display("[TB] FAIL t6_setup: got rvalid=%b awready=%b, expected 1/0", rvalid, awready); end
        aresetn = 0; tick(); aresetn = 1;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        nCompared++; if ({bvalid, rvalid} !== 2'b00) begin nMismatched++; $display("[TB] FAIL t6_valids: got %b, expected 00", {bvalid, rvalid}); end
        nCompared++; if (regQ !== modelFlat()) begin nMismatched++; $display("[TB] FAIL t6_regq: got %h, expected %h", regQ, modelFlat()); end
        wvalid = 1; wdata = 32'h00000077; wstrb = 4'hF;
        tick();
        wvalid = 0;
        nB = 0;
        repeat (4) begin if (bvalid) nB++; tick(); end
        nCompared++; if (nB !== 0 || regOf(6) !== 32'h0) begin nMismatched++; $display("[TB] FAIL t6_dropped_aw: got bcycles=%0d reg6=%h, expected 0/0", nB, regOf(6)); end
        awvalid = 1; awaddr = 32'h1C; tick(); awvalid = 0; tick();
        void'(modelWrite(32'h1C, 32'h00000077, 4'hF));
        nCompared++; if (bvalid !== 1'b1 || regOf(7) !== model[7]) begin nMismatched++; $display("[TB] FAIL t6_fresh_write: got v=%b reg7=%h, expected v=1 reg7=%h", bvalid, regOf(7), model[7]); end
        bready = 1; tick(); bready = 0;
    endtask

    task automatic test_random();
        logic [31:0] addr, data, d;
        logic [3:0] strb;
        logic [1:0] r, expResp;
        int idx;
        for (int k = 0; k < 60; k++) begin
            idx = $urandom_range(0, NREGS + 3);
            addr = 32'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                doWrite(addr, data, strb, r);
                expResp = modelWrite(addr, data, strb);
                nCompared++; if (r !== expResp) begin nMismatched++; $display("[TB] FAIL rnd_bresp addr=%h: got %b, expected %b", addr, r, expResp); end
                nCompared++; if (regQ !== modelFlat()) begin nMismatched++; $display("[TB] FAIL rnd_regq addr=%h: got %h, expected %h", addr, regQ, modelFlat()); end
            end else begin
                doRead(addr, d, r);
                nCompared++; if (idx < NREGS ? (d !== model[idx] || r !== 2'b00) : (d !== 32'h0 || r !== 2'b10)) begin
                    nMismatched++; $display("[TB] FAIL rnd_read addr=%h: got %h/%b, expected %h", addr, d, r, (idx < NREGS) ? model[idx] : 32'h0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_w_before_aw();
        test_slverr();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
